// File: rtl/hq2x_line_feeder.sv
// hq2x_line_feeder: captures source lines into a ping-pong store and replays each pixel on four ce_in strobes to an HQ2x scaler.
// Define HQ2X_FEED_STATS_EN to add the line_count/drop_count outputs.
module hq2x_line_feeder #(
  parameter int LENGTH = 1024,
  parameter int CE_DIV = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic        de,
  input  logic        vs,
  input  logic [23:0] rgb,
  output logic        ce_in,
  output logic [23:0] inputpixel,
  output logic        reset_line,
  output logic        reset_frame,
  output logic        busy,
`ifdef HQ2X_FEED_STATS_EN
  output logic [11:0] line_count,
  output logic [7:0]  drop_count,
`endif
  output logic        overrun
);
  localparam int AW = $clog2(LENGTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  typedef enum logic [1:0] {IDLE, RSTL, RUN, FLUSH} state_t;
  state_t r_state, w_nxt;
  logic [23:0] r_mem [2*LENGTH];
  logic [23:0] r_rd;
  logic [AW:0] r_wcnt, w_wptr;
  logic [AW:0] r_len [2];
  logic [AW-1:0] r_idx, w_raddr;
  logic [1:0] r_full, w_set, w_clr, r_sub;
  logic [3:0] r_div;
  logic r_cap, r_play, r_cap_act, r_de_prev, r_vs_prev, r_rf_second;
  logic w_pix, w_wr, w_done, w_acc, w_drop, w_cap_free, w_fin, w_last4, w_last_px, w_vs_rise, w_ovf;
  assign w_vs_rise = ce_pix && vs && !r_vs_prev;
  assign w_pix = ce_pix && de && (!r_de_prev || r_cap_act);
  assign w_wptr = r_de_prev ? r_wcnt : '0;
  // r_wcnt saturates at LENGTH, so its top bit alone flags a full line
  assign w_ovf = w_pix && w_wptr[AW];
  assign w_last4 = ce_in && r_sub == 2'd3;
  assign w_last_px = w_last4 && {1'b0, r_idx} + ONE == r_len[r_play];
  assign w_fin = r_state == FLUSH && w_last4;
  assign w_cap_free = !r_full[r_cap] || (w_fin && r_play == r_cap);
  assign w_wr = w_pix && !w_wptr[AW] && w_cap_free;
  assign w_done = ce_pix && !de && r_de_prev && r_cap_act && r_wcnt != '0;
  assign w_acc = w_done && w_cap_free;
  assign w_drop = w_done && !w_cap_free;
  assign w_set = {w_acc && r_cap, w_acc && !r_cap};
  assign w_clr = {w_fin && r_play, w_fin && !r_play};
  // prefetch the next pixel on the last strobe of the current one so RUN has no bubble
  assign w_raddr = (r_state == RUN && w_last4) ? r_idx + ONE[AW-1:0] : r_idx;
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[{r_cap, w_wptr[AW-1:0]}] <= rgb;
    r_rd <= r_mem[{r_play, w_raddr}];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = r_full[r_play] ? RSTL : IDLE;
      RSTL:    w_nxt = w_last4 ? RUN : RSTL;
      RUN:     w_nxt = w_last_px ? FLUSH : RUN;
      FLUSH:   w_nxt = w_last4 ? ((r_full[~r_play] || w_acc) ? RSTL : IDLE) : FLUSH;
      default: w_nxt = IDLE;
    endcase
  end
  always_comb begin
    ce_in = r_state != IDLE && r_div == '0;
    reset_line = r_state == RSTL;
    inputpixel = r_state == RUN ? r_rd : '0;
    busy = r_state != IDLE || |r_full;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_div <= '0;
      r_sub <= '0;
      r_idx <= '0;
      r_play <= 1'b0;
      r_cap <= 1'b0;
      r_full <= '0;
      r_len <= '{default: '0};
      r_wcnt <= '0;
      r_cap_act <= 1'b0;
      r_de_prev <= 1'b1;
      r_vs_prev <= 1'b0;
      overrun <= 1'b0;
      reset_frame <= 1'b0;
      r_rf_second <= 1'b0;
    end else begin
      r_div <= (w_nxt == IDLE || r_div == 4'(CE_DIV - 1)) ? '0 : r_div + 4'd1;
      if (ce_in) r_sub <= r_sub + 2'd1;
      r_idx <= (r_state != RUN || w_last_px) ? '0 : w_raddr;
      r_play <= r_play ^ w_fin;
      r_cap <= r_cap ^ w_acc;
      r_full <= (r_full & ~w_clr) | w_set;
      if (w_acc) r_len[r_cap] <= r_wcnt;
      if (ce_pix) begin
        r_de_prev <= de;
        r_vs_prev <= vs;
      end
      if (w_pix) r_wcnt <= w_wptr[AW] ? w_wptr : w_wptr + ONE;
      if (ce_pix && de && !r_de_prev) r_cap_act <= 1'b1;
      else if (ce_pix && !de) r_cap_act <= 1'b0;
      overrun <= (overrun && !w_vs_rise) || w_ovf || w_drop;
      // the scaler clears its buffers when reset_frame falls at the end of the second line's reset
      if (w_vs_rise) begin
        reset_frame <= 1'b1;
        r_rf_second <= 1'b0;
      end else if (r_state == RSTL && w_last4 && reset_frame) begin
        reset_frame <= !r_rf_second;
        r_rf_second <= 1'b1;
      end
    end
`ifdef HQ2X_FEED_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      line_count <= '0;
      drop_count <= '0;
    end else if (w_vs_rise) begin
      line_count <= '0;
      drop_count <= '0;
    end else begin
      if (w_done) line_count <= line_count + 12'd1;
      if (w_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
`endif
endmodule

// File: doc/hq2x_line_feeder.md
HQ2X_LINE_FEEDER -- requirements
Module: hq2x_line_feeder

Interface
REQ-001 SHALL have parameter LENGTH, default 1024, maximum active pixels per line (power of two).
REQ-002 SHALL have parameter CE_DIV, default 1, clk cycles between successive ce_in strobes (1..15).
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port ce_pix  in  1  source pixel enable; de/vs/rgb sampled only when high.
REQ-006 SHALL have port de  in  1  source active-video flag.
REQ-007 SHALL have port vs  in  1  source vertical sync, active high.
REQ-008 SHALL have port rgb  in  24  source pixel {B,G,R}.
REQ-009 SHALL have port ce_in  out  1  strobe to the scaler's ce_in.
REQ-010 SHALL have port inputpixel  out  24  pixel to the scaler.
REQ-011 SHALL have port reset_line  out  1  line-start marker to the scaler.
REQ-012 SHALL have port reset_frame  out  1  frame-start marker to the scaler.
REQ-013 SHALL have port busy  out  1  high while any line is replaying or pending.
REQ-014 SHALL have port overrun  out  1  sticky: a line or pixels were dropped; cleared on vs rising edge.

Function
REQ-015 SHALL capture pixels with ce_pix&de into a ping-pong line store of 2xLENGTH words, write address from 0.
REQ-016 SHALL drop pixels beyond LENGTH in one line and set overrun.
REQ-017 SHALL mark a line complete on de falling edge (sampled on ce_pix); zero-length lines ignored.
REQ-018 SHALL replay via FSM states IDLE -> RSTL -> RUN -> FLUSH -> IDLE, advancing only on ce_in strobes.
REQ-019 SHALL leave IDLE when a complete line exists; first ce_in of RSTL one clk after completion detected (CE_DIV=1).
REQ-020 RSTL: 4 ce_in strobes with reset_line=1, inputpixel=0; reset_line drops after the 4th strobe.
REQ-021 RUN: each stored pixel held on inputpixel for exactly 4 consecutive ce_in strobes, index 0..N-1; store read latency hidden (no bubble).
REQ-022 FLUSH: 4 ce_in strobes with inputpixel=0, then IDLE or directly RSTL if another line is pending.
REQ-023 ce_in SHALL be a single-clk pulse every CE_DIV clks while not IDLE, and 0 in IDLE.
REQ-024 reset_frame SHALL rise on vs rising edge and fall with reset_line fall of the second line replayed after it (scaler resets buffers on that transition).
REQ-025 Replay buffer and capture buffer SHALL always differ; one completed line may pend while another replays.
REQ-026 A line completing while one replays and one pends SHALL be discarded and set overrun; pending line unaffected.
REQ-027 Capture starting while both buffers occupied SHALL write nowhere until a buffer frees.
REQ-028 Simultaneous completion and replay-finish SHALL queue the new line; no line lost, no overrun.
REQ-029 Pixel count per line SHALL be stored $clog2(LENGTH)+1 bits wide so N=LENGTH is exact.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, ce_in=0, inputpixel=0, reset_line=0, reset_frame=0, busy=0, overrun=0, both buffers empty.
REQ-031 Reset mid-line or mid-replay SHALL abandon all lines; store contents need not be cleared.
REQ-032 After reset release, capture SHALL start only at the next de rising edge.

Configuration
REQ-033 Macro HQ2X_FEED_STATS_EN defined: adds outputs line_count[11:0] (completed lines since last vs rise) and drop_count[7:0] (saturating dropped lines), both reset to 0 and cleared on vs rise.
REQ-034 Macro undefined: neither port nor its counters SHALL exist; all other behaviour identical.

Verification
REQ-035 One 8-pixel line 0x000001..0x000008, CE_DIV=1 -> 4 reset_line strobes, 32 strobes each value x4 in order, 4 zero strobes, total 40 ce_in, busy low after.
REQ-036 Line of LENGTH+3 pixels -> exactly LENGTH pixels replayed, overrun=1; vs rise -> overrun=0.
REQ-037 Three 4-pixel lines back-to-back, replay slowed by CE_DIV=8 -> lines 1,2 replayed, line 3 dropped, overrun=1, drop_count=1 with macro.
REQ-038 vs rise then two lines -> reset_frame high through line 1, falls with line 2's reset_line fall.
REQ-039 reset_n low during RUN at strobe 10 -> all outputs 0 same cycle; next full line replays normally.
REQ-040 CE_DIV=3, 2-pixel line -> ce_in pulses spaced 3 clks, 16 strobes total.
